fifo_rd_streamer: RTL and testbench

Drains the synchronous FIFO's read port and presents its contents as a valid/ready stream to the downstream consumer. The block drives the FIFO read enable and absorbs the FIFO's one-cycle registered read latency in a small skid buffer, so it sustains one word per cycle under continuous ready. It also groups words into fixed-length bursts and marks the final beat of each burst with o_last.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/stream_skid_buf.sv | 67 ++++++
 rtl/fifo_rd_streamer.sv | 84 ++++++++
 tb/tb_fifo_rd_streamer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO, its interface and its read-side streamer.
// DATA_W : word width carried through the FIFO.
// data_t : one FIFO word.
package fifo_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular buffer that absorbs words already requested from the FIFO.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   push      : write wdata at the tail this cycle
//   pop       : drop the head this cycle
//   wdata     : word to write
//   rdata     : current head word (meaningful while count != 0)
//   count     : number of buffered words
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = fifo_pkg::DATA_W,
  parameter int unsigned SKID_DEPTH = 3,
  localparam int unsigned CNT_W     = $clog2(SKID_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointer advance with explicit wrap at SKID_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

  // The read-credit scheme upstream guarantees there is always room for a push.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    push |-> ((count < CNT_W'(SKID_DEPTH)) || pop));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO (one-cycle registered read) into a valid/ready stream,
// grouping beats into fixed-length bursts.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   o_rden     : FIFO read request (combinational)
//   i_empty    : FIFO empty flag
//   i_rddata   : FIFO read data, valid the cycle after an accepted read
//   o_valid    : stream word available
//   i_ready    : downstream accepts the word
//   o_data     : stream word
//   o_last     : final beat of a burst
//   o_beat_cnt : beat index within the current burst
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = fifo_pkg::DATA_W,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned SKID_DEPTH = 3,
  localparam int unsigned BEAT_W    = $clog2(BURST_LEN) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              o_rden,
  input  logic              i_empty,
  input  logic [DATA_W-1:0] i_rddata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [BEAT_W-1:0] o_beat_cnt
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);

  logic             inflight;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             credit_ok;
  logic             at_last;

  stream_skid_buf #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (i_rddata),
    .rdata (o_data),
    .count (count)
  );

  // A read is only issued when the buffer can hold it alongside any word still in flight.
  assign credit_ok = ((CNT_W + 1)'(count) + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(SKID_DEPTH);
  assign o_rden    = rstn && !i_empty && credit_ok;

  assign push    = inflight;
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;

  assign at_last = (o_beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign o_last  = o_valid && at_last;

  // In-flight flag: the FIFO returns data one cycle after an accepted read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= o_rden;
    end
  end

  // Beat position within the burst; holds across empty gaps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_beat_cnt <= '0;
    end else if (pop) begin
      o_beat_cnt <= at_last ? '0 : o_beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int SD = 3;
  localparam int BW = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          o_rden;
  logic          i_empty = 1'b0;
  logic [DW-1:0] i_rddata = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [BW-1:0] o_beat_cnt;

  fifo_rd_streamer #(.DATA_W(DW), .BURST_LEN(BL), .SKID_DEPTH(SD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .o_rden     (o_rden),
    .i_empty    (i_empty),
    .i_rddata   (i_rddata),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_beat_cnt (o_beat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Upstream FIFO contents and reference model of words owed to the stream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            st_q[$];      // cycle in which each owed word was read
  int            model_beat = 0;
  int            cyc = 0;

  // Transfer log for the literal checks.
  logic [DW-1:0] log_d[$];
  logic          log_l[$];
  int            log_b[$];
  int            log_c[$];

  bit            hold_p = 0;
  logic [DW-1:0] hold_d;
  bit            tog_mode = 0;
  bit            tog = 0;
  bit            rnd_ready = 0;
  int            first_rd = -1;
  int            first_val = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs at negedge, then advance the FIFO model after posedge.
  task automatic cycle();
    bit            rd_s;
    bit            xv;
    logic [DW-1:0] w;
    @(negedge clk);
    xv = (exp_q.size() > 0) && (st_q[0] + 2 <= cyc);
    chk("rden", int'(o_rden), int'(!i_empty && exp_q.size() < SD));
    chk("valid", int'(o_valid), int'(xv));
    chk("beat_cnt", int'(o_beat_cnt), model_beat);
    chk("last", int'(o_last), int'(xv && model_beat == BL - 1));
    if (hold_p) chk("hold_data", int'(o_data), int'(hold_d));
    if (xv) chk("data", int'(o_data), int'(exp_q[0]));
    if (o_valid && i_ready) begin
      log_d.push_back(o_data);
      log_l.push_back(o_last);
      log_b.push_back(int'(o_beat_cnt));
      log_c.push_back(cyc);
    end
    if (xv && i_ready) begin
      void'(exp_q.pop_front());
      void'(st_q.pop_front());
      model_beat = (model_beat + 1) % BL;
    end
    if (first_val < 0 && o_valid) first_val = cyc;
    hold_p = o_valid && !i_ready;
    hold_d = o_data;
    rd_s   = o_rden;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hEE;
      i_rddata = w;
      exp_q.push_back(w);
      st_q.push_back(cyc - 1);
      if (first_rd < 0) first_rd = cyc - 1;
    end
    if (tog_mode) tog = !tog;
    i_empty = (tog_mode && tog) || (fifo_q.size() == 0);
    if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  // Asynchronous reset with immediate output checks; the FIFO shares the reset.
  task automatic do_reset();
    i_empty = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("rst_rden", int'(o_rden), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_beat", int'(o_beat_cnt), 0);
    fifo_q.delete(); exp_q.delete(); st_q.delete();
    log_d.delete(); log_l.delete(); log_b.delete(); log_c.delete();
    model_beat = 0; hold_p = 0; tog_mode = 0; tog = 0; rnd_ready = 0;
    first_rd = -1; first_val = -1;
    repeat (2) @(posedge clk);
    #2;
    rstn    = 1'b1;
    i_empty = 1'b1;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    i_empty = (fifo_q.size() == 0);
  endtask

  logic [DW-1:0] src[$];

  initial begin
    // Streaming: back-to-back burst of 8 words.
    do_reset();
    i_ready = 1'b1;
    load(8'h10, 8);
    for (int k = 0; k < 100 && log_d.size() < 8; k++) cycle();
    chk("stream_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_data", int'(log_d[i]), 'h10 + i);
        chk("stream_last", int'(log_l[i]), int'(i % 4 == 3));
        chk("stream_beat", log_b[i], i % 4);
      end
      chk("stream_no_bubble", log_c[7] - log_c[0], 7);
    end
    chk("first_latency", first_val - first_rd, 2);

    // Backpressure after beat 0x11.
    do_reset();
    i_ready = 1'b1;
    load(8'h10, 8);
    for (int k = 0; k < 100 && log_d.size() < 2; k++) cycle();
    i_ready = 1'b0;
    repeat (5) cycle();
    chk("bp_hold_data", int'(o_data), 'h12);
    chk("bp_rden_off", int'(o_rden), 0);
    i_ready = 1'b1;
    for (int k = 0; k < 100 && log_d.size() < 8; k++) cycle();
    chk("bp_count", log_d.size(), 8);
    if (log_d.size() == 8)
      for (int i = 0; i < 8; i++) chk("bp_data", int'(log_d[i]), 'h10 + i);

    // FIFO-empty gap in the middle of a burst.
    do_reset();
    i_ready = 1'b1;
    load(8'hA0, 2);
    for (int k = 0; k < 50 && log_d.size() < 2; k++) cycle();
    repeat (10) cycle();
    chk("gap_valid", int'(o_valid), 0);
    chk("gap_beat", int'(o_beat_cnt), 2);
    load(8'hA2, 2);
    for (int k = 0; k < 50 && log_d.size() < 4; k++) cycle();
    chk("gap_count", log_d.size(), 4);
    if (log_d.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("gap_data", int'(log_d[i]), 'hA0 + i);
        chk("gap_last", int'(log_l[i]), int'(i == 3));
      end

    // Reset mid-burst with a read in flight.
    do_reset();
    i_ready = 1'b1;
    load(8'h30, 8);
    for (int k = 0; k < 50 && log_d.size() < 2; k++) cycle();
    do_reset();
    i_ready = 1'b1;
    load(8'h50, 4);
    for (int k = 0; k < 50 && log_d.size() < 4; k++) cycle();
    chk("rst_mid_count", log_d.size(), 4);
    if (log_d.size() > 0) begin
      chk("rst_mid_first", int'(log_d[0]), 'h50);
      chk("rst_mid_beat0", log_b[0], 0);
    end

    // Toggling empty flag with random backpressure; scoreboard against write order.
    do_reset();
    src.delete();
    for (int i = 0; i < 40; i++) begin
      src.push_back(DW'($urandom));
      fifo_q.push_back(src[i]);
    end
    i_empty   = 1'b0;
    tog_mode  = 1;
    rnd_ready = 1;
    i_ready   = 1'b1;
    for (int k = 0; k < 2000 && log_d.size() < 40; k++) cycle();
    chk("rand_count", log_d.size(), 40);
    if (log_d.size() == 40)
      for (int i = 0; i < 40; i++) chk("rand_order", int'(log_d[i]), int'(src[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
